ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register. Consumes the current PC, issues one request per instruction on a req/gnt/rvalid instruction-memory port, and presents the fetched word to decode with a valid/ready handshake.
- Drives pc_en back to the PC register, so the PC advances exactly once per delivered instruction or flush.
- Adds bus-error and timeout detection; faulted fetches are delivered as a NOP with a cause code.

Parameters:
- TIMEOUT, 255, max cycles in WAIT without imem_rvalid before declaring a timeout (1..255, 8-bit counter).
- NOP_INSTR, 32'h0000_0013, word substituted on any fault.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc  in  32  current PC from PC register
- pc_en  out  1  PC register load enable (advance/redirect)
- flush  in  1  redirect strobe; PC register loads the redirect target this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response data
- imem_err  in  1  response error, qualified by imem_rvalid
- instr  out  32  fetched instruction
- instr_pc  out  32  PC of instr
- instr_valid  out  1  instr available
- instr_ready  in  1  decode accepts instr
- fetch_err  out  1  instr is a faulted NOP
- err_cause  out  2  0 none, 1 bus error, 2 timeout, 3 misaligned

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high on rst.
  - Reset: state IDLE, instr=NOP_INSTR, instr_pc=0, fetch_err=0, err_cause=0, timeout counter=0.
  - Outputs are decoded from state, so imem_req, instr_valid and pc_en are all 0 while rst is high.
- FSM states: IDLE, REQ, WAIT, VALID, DRAIN.
  - IDLE: go to REQ on the next cycle unconditionally.
  - REQ: imem_req=1, imem_addr=pc (combinational), and pc holds because pc_en=0.
    - On imem_gnt, latch instr_pc=pc, clear the counter, and go to WAIT.
  - WAIT: the counter increments each cycle.
    - On imem_rvalid, go to VALID and set instr = imem_err ? NOP_INSTR : imem_rdata, fetch_err=imem_err, err_cause = imem_err ? 1 : 0.
    - If the counter reaches TIMEOUT with no rvalid, go to VALID with instr=NOP_INSTR, fetch_err=1, err_cause=2.
  - VALID: instr_valid=1 and instr, instr_pc, fetch_err, err_cause are stable.
    - On instr_valid && instr_ready, pc_en=1 for that cycle and the next state is REQ.
  - DRAIN: wait for the orphaned response.
    - On imem_rvalid, discard the data and go to REQ.
    - On TIMEOUT, go to REQ with no error reported.
- Minimum latency: req→gnt same cycle, rvalid next cycle, instr_valid the cycle after. Best-case throughput is 1 instruction per 3 cycles.
- At most one request outstanding. imem_req never asserts in WAIT, VALID or DRAIN.
- imem_rvalid outside WAIT and DRAIN is ignored.
- flush has highest priority and forces pc_en=1 that cycle:
  - REQ without gnt: stay in REQ; the address follows the new pc next cycle.
  - REQ with gnt same cycle: go to DRAIN.
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid same cycle: discard the data and go to REQ.
  - VALID: drop the instruction (instr_valid=0 next cycle) and go to REQ. No pc_en double pulse occurs even if instr_ready is also high.
  - IDLE or DRAIN: the state is unchanged.
- Reset mid-transaction returns to IDLE. Late responses from the aborted request arrive while in IDLE or REQ and are ignored.

Optional Feature:
- FETCH_ALIGN_CHK_EN defined: in REQ, if pc[1:0]!=0, no request is issued. The next state is VALID with instr=NOP_INSTR, instr_pc=pc, fetch_err=1, err_cause=3.
- Not defined: no alignment check. imem_addr=pc as-is, and err_cause 3 is never produced.

Decomposition:
- Shared package ifetch_pkg:
  - FSM state encoding (3-bit)
  - err_cause constants CAUSE_NONE/BUS/TIMEOUT/MISALIGN
  - NOP_INSTR default
- Sub-module ifetch_timeout_ctr: 8-bit counter with clear, enable and a hit flag compared against TIMEOUT.

Test Plan:
- Reset then pc=0x0000_0000, gnt same cycle, rvalid next cycle with rdata=0x0050_0093 → instr_valid on cycle 3 with instr=0x0050_0093 and instr_pc=0; with ready=1, pc_en pulses once.
- Back-pressure: instr_ready=0 for 5 cycles → instr, instr_pc stable and pc_en=0 throughout; one pc_en pulse on acceptance.
- imem_err=1 with rvalid at pc=0x10 → instr=0x0000_0013, fetch_err=1, err_cause=1.
- No rvalid for TIMEOUT=4 cycles → VALID with err_cause=2. A late rvalid arriving in REQ is ignored.
- flush in WAIT at pc=0x20, redirect to 0x100 → pc_en=1, state DRAIN, the next rvalid data is discarded; the next imem_addr=0x100 and no stale instr is delivered.
- With FETCH_ALIGN_CHK_EN, pc=0x0000_0102 → imem_req stays 0, instr_valid with fetch_err=1 and err_cause=3.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, fault
// cause codes and the default substitute instruction.
package ifetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_BUS      = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/ifetch_timeout_ctr.sv
// Response watchdog for the fetch port: 8-bit counter with clear and enable;
// hit flags the cycle on which the count would reach TIMEOUT.
module ifetch_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Firing one count early makes the TIMEOUT-th waiting cycle the last one.
    assign hit = (cnt == LIMIT);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding req/gnt/rvalid fetch, valid/ready
// delivery to decode, bus-error and timeout faults delivered as a NOP.
// Optional alignment check enabled by defining FETCH_ALIGN_CHK_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic [1:0]  err_cause
);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic [1:0]  cause_q, cause_d;

    logic ctr_clr, ctr_en, ctr_hit;
    logic req_c, valid_c, pc_en_c;
    logic misalign;

    ifetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (ctr_en),
        .hit (ctr_hit)
    );

`ifdef FETCH_ALIGN_CHK_EN
    assign misalign = (pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        fetch_err_d = fetch_err_q;
        cause_d     = cause_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        req_c       = 1'b0;
        valid_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!flush) state_d = ST_REQ;
            end

            ST_REQ: begin
                ctr_clr = 1'b1;
                if (misalign) begin
                    // Faulted without touching the bus; flush still wins.
                    if (!flush) begin
                        state_d     = ST_VALID;
                        instr_d     = NOP_INSTR;
                        instr_pc_d  = pc;
                        fetch_err_d = 1'b1;
                        cause_d     = CAUSE_MISALIGN;
                    end
                end else begin
                    req_c = 1'b1;
                    if (flush) begin
                        if (imem_gnt) state_d = ST_DRAIN;
                    end else if (imem_gnt) begin
                        instr_pc_d = pc;
                        state_d    = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                ctr_en = 1'b1;
                if (flush) begin
                    // Restart the watchdog so DRAIN gets a full window.
                    ctr_clr = 1'b1;
                    state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
                end else if (imem_rvalid) begin
                    state_d     = ST_VALID;
                    instr_d     = imem_err ? NOP_INSTR : imem_rdata;
                    fetch_err_d = imem_err;
                    cause_d     = imem_err ? CAUSE_BUS : CAUSE_NONE;
                end else if (ctr_hit) begin
                    state_d     = ST_VALID;
                    instr_d     = NOP_INSTR;
                    fetch_err_d = 1'b1;
                    cause_d     = CAUSE_TIMEOUT;
                end
            end

            ST_VALID: begin
                valid_c = 1'b1;
                if (flush || instr_ready) state_d = ST_REQ;
            end

            ST_DRAIN: begin
                ctr_en = 1'b1;
                if (!flush && (imem_rvalid || ctr_hit)) state_d = ST_REQ;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush and an acceptance in the same cycle still give one pulse.
        pc_en_c = flush || (valid_c && instr_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q     <= NOP_INSTR;
            instr_pc_q  <= 32'd0;
            fetch_err_q <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fetch_err_q <= fetch_err_d;
            cause_q     <= cause_d;
        end
    end

    assign imem_req    = req_c   && !rst;
    assign instr_valid = valid_c && !rst;
    assign pc_en       = pc_en_c && !rst;
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;
    assign err_cause   = cause_q;

endmodule
